bolme_sirali_denetleyici: RTL

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU. Sits in the execute stage beside the main ALU.

---
 rtl/bolme_sirali_denetleyici_pkg.sv | 31 +++
 rtl/bolme_sirali_denetleyici_if.sv | 25 ++
 rtl/bolme_sirali_denetleyici_amb.sv | 24 ++
 rtl/bolme_sirali_denetleyici.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bolme_sirali_denetleyici_pkg.sv
// Shared types and constants for the multi-cycle RV32M divide/remainder sequencer
// and the private ALU it drives.
package bolme_sirali_denetleyici_pkg;

  localparam int BOLME_GENISLIK = 32;

  typedef enum logic [1:0] {
    BOLME_DIV  = 2'b00,
    BOLME_DIVU = 2'b01,
    BOLME_REM  = 2'b10,
    BOLME_REMU = 2'b11
  } bolme_islem_t;

  typedef enum logic [1:0] {
    BOLME_BOSTA   = 2'b00,
    BOLME_HESAPLA = 2'b01,
    BOLME_DUZELT  = 2'b10
  } bolme_durum_t;

  localparam logic [3:0] AMB_TOPLAMA = 4'd0;
  localparam logic [3:0] AMB_CIKARMA = 4'd1;
  localparam logic [3:0] AMB_VE      = 4'd2;
  localparam logic [3:0] AMB_VEYA    = 4'd3;
  localparam logic [3:0] AMB_XOR     = 4'd4;

  // Two's-complement negation, used for |operand| and for the final sign fix.
  function automatic logic [BOLME_GENISLIK-1:0] isaret_degistir(input logic [BOLME_GENISLIK-1:0] x);
    return ~x + {{(BOLME_GENISLIK-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/bolme_sirali_denetleyici_if.sv
// Request/response bundle between the execute stage (master) and the divide
// sequencer (slave).
interface bolme_sirali_denetleyici_if;
  import bolme_sirali_denetleyici_pkg::*;

  logic                      basla_i;
  bolme_islem_t              islem_i;
  logic [BOLME_GENISLIK-1:0] bolunen_i;
  logic [BOLME_GENISLIK-1:0] bolen_i;
  logic                      iptal_i;
  logic                      mesgul_o;
  logic                      gecerli_o;
  logic [BOLME_GENISLIK-1:0] sonuc_o;

  modport master (
    output basla_i, islem_i, bolunen_i, bolen_i, iptal_i,
    input  mesgul_o, gecerli_o, sonuc_o
  );

  modport slave (
    input  basla_i, islem_i, bolunen_i, bolen_i, iptal_i,
    output mesgul_o, gecerli_o, sonuc_o
  );

endinterface

// File: rtl/bolme_sirali_denetleyici_amb.sv
// Small combinational 32-bit ALU; the divide sequencer uses only its subtract
// path for the trial subtraction of each restoring step.
module aritmetik_mantik_birimi
  import bolme_sirali_denetleyici_pkg::*;
(
  input  logic [3:0]  kontrol_i,
  input  logic [31:0] islec1_i,
  input  logic [31:0] islec2_i,
  output logic [31:0] sonuc_o
);

  always_comb begin
    sonuc_o = '0;
    case (kontrol_i)
      AMB_TOPLAMA: sonuc_o = islec1_i + islec2_i;
      AMB_CIKARMA: sonuc_o = islec1_i - islec2_i;
      AMB_VE:      sonuc_o = islec1_i & islec2_i;
      AMB_VEYA:    sonuc_o = islec1_i | islec2_i;
      AMB_XOR:     sonuc_o = islec1_i ^ islec2_i;
      default:     sonuc_o = '0;
    endcase
  end

endmodule

// File: rtl/bolme_sirali_denetleyici.sv
// 32-step restoring divider for DIV/DIVU/REM/REMU. Divide-by-zero and signed
// overflow skip the iteration and finish one cycle after accept.
module bolme_sirali_denetleyici
  import bolme_sirali_denetleyici_pkg::*;
#(
  parameter int VERI_GENISLIGI = 32
) (
  input logic                      clk_i,
  input logic                      rst_i,
  bolme_sirali_denetleyici_if.slave bus
);

  localparam int W = VERI_GENISLIGI;

  bolme_durum_t durum, sonraki_durum;

  logic [W-1:0] kalan, bolum, bolen_r, kalan_kay, amb_sonuc, duzeltilmis;
  logic [W-1:0] bolunen_abs, bolen_abs, sonuc_r;
  logic [4:0]   sayac;
  bolme_islem_t islem_r;
  logic         bolunen_negatif, bolen_negatif, ozel;
  logic         isaretli, sifir_bolen, tasma, ozel_giris;
  logic         kabul, adim, bitir, al, gecerli_r;

  always_comb begin
    isaretli    = ~bus.islem_i[0];
    bolunen_abs = (isaretli && bus.bolunen_i[W-1]) ? isaret_degistir(bus.bolunen_i) : bus.bolunen_i;
    bolen_abs   = (isaretli && bus.bolen_i[W-1]) ? isaret_degistir(bus.bolen_i) : bus.bolen_i;
    sifir_bolen = (bus.bolen_i == '0);
    tasma       = isaretli && (bus.bolunen_i == {1'b1, {(W-1){1'b0}}}) && (bus.bolen_i == '1);
    ozel_giris  = sifir_bolen || tasma;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum <= BOLME_BOSTA;
    else        durum <= sonraki_durum;
  end

  always_comb begin
    sonraki_durum = durum;
    if (bus.iptal_i) begin
      sonraki_durum = BOLME_BOSTA;
    end else begin
      case (durum)
        BOLME_BOSTA:   if (bus.basla_i) sonraki_durum = ozel_giris ? BOLME_DUZELT : BOLME_HESAPLA;
        BOLME_HESAPLA: if (sayac == 5'd0) sonraki_durum = BOLME_DUZELT;
        BOLME_DUZELT:  sonraki_durum = BOLME_BOSTA;
        default:       sonraki_durum = BOLME_BOSTA;
      endcase
    end
  end

  always_comb begin
    kabul        = (durum == BOLME_BOSTA) && bus.basla_i && !bus.iptal_i;
    adim         = (durum == BOLME_HESAPLA) && !bus.iptal_i;
    bitir        = (durum == BOLME_DUZELT) && !bus.iptal_i;
    bus.mesgul_o = (durum != BOLME_BOSTA);
  end

  // The remainder's MSB shifted out (t) marks a 33-bit partial remainder that
  // always exceeds the divisor, so the wrapped ALU difference is still correct.
  always_comb begin
    kalan_kay = {kalan[W-2:0], bolum[W-1]};
    al        = kalan[W-1] | (kalan_kay >= bolen_r);
  end

  aritmetik_mantik_birimi u_amb (
    .kontrol_i (AMB_CIKARMA),
    .islec1_i  (kalan_kay),
    .islec2_i  (bolen_r),
    .sonuc_o   (amb_sonuc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kalan           <= '0;
      bolum           <= '0;
      bolen_r         <= '0;
      sayac           <= '0;
      islem_r         <= BOLME_DIV;
      bolunen_negatif <= 1'b0;
      bolen_negatif   <= 1'b0;
      ozel            <= 1'b0;
    end else if (kabul) begin
      bolen_r         <= bolen_abs;
      islem_r         <= bus.islem_i;
      bolunen_negatif <= isaretli && bus.bolunen_i[W-1];
      bolen_negatif   <= isaretli && bus.bolen_i[W-1];
      sayac           <= 5'd31;
      ozel            <= ozel_giris;
      if (sifir_bolen) begin
        bolum <= '1;
        kalan <= bus.bolunen_i;
      end else if (tasma) begin
        bolum <= {1'b1, {(W-1){1'b0}}};
        kalan <= '0;
      end else begin
        bolum <= bolunen_abs;
        kalan <= '0;
      end
    end else if (adim) begin
      kalan <= al ? amb_sonuc : kalan_kay;
      bolum <= {bolum[W-2:0], al};
      sayac <= sayac - 5'd1;
    end
  end

  // Special-case results are already final, so the sign fix is bypassed for them.
  always_comb begin
    duzeltilmis = '0;
    case (islem_r)
      BOLME_DIV:  duzeltilmis = (!ozel && (bolunen_negatif != bolen_negatif)) ? isaret_degistir(bolum) : bolum;
      BOLME_DIVU: duzeltilmis = bolum;
      BOLME_REM:  duzeltilmis = (!ozel && bolunen_negatif) ? isaret_degistir(kalan) : kalan;
      BOLME_REMU: duzeltilmis = kalan;
      default:    duzeltilmis = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gecerli_r <= 1'b0;
      sonuc_r   <= '0;
    end else begin
      gecerli_r <= bitir;
      if (bitir) sonuc_r <= duzeltilmis;
    end
  end

  assign bus.gecerli_o = gecerli_r;
  assign bus.sonuc_o   = sonuc_r;

endmodule
